// File: rtl/ram_rd_pkg.sv
// Shared constants, state encoding and sizing helper for the RAM stream reader.
package ram_rd_pkg;

  localparam int RAM_RD_LATENCY = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Register FIFO used as the output skid buffer; read data is the head entry.
module rd_skid_fifo
  import ram_rd_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int SKID_DEPTH = 4,
  localparam int CW         = cnt_width(SKID_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         count
);

  localparam int PW = $clog2(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;

  // Storage carries no reset; contents are only visible behind a nonzero count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader for a 2-cycle-latency RAM read port, presenting a valid/ready stream.
// Optional macro RAM_RD_LAST_EN adds m_last, carried through the skid buffer.
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int SKID_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [DATA_WIDTH-1:0]    ram_read_data,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
`ifdef RAM_RD_LAST_EN
  output logic                     m_last,
`endif
  input  logic                     m_ready
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = cnt_width(SKID_DEPTH);
  localparam int IW = $clog2(RAM_RD_LATENCY + 1);
`ifdef RAM_RD_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  rd_state_e                 state, state_nxt;
  logic [AW:0]               len_q, issued_q, rem_q;
  logic [AW-1:0]             addr_q;
  logic [RAM_RD_LATENCY-1:0] vld_pipe;
  logic [IW-1:0]             inflight;
  logic [CW-1:0]             occ;
  logic [CW:0]               used;
  logic                      issue, last_issue, hs, final_hs, accept;
  logic [FW-1:0]             fifo_wdata, fifo_rdata;

  assign accept     = (state == IDLE) && start && (length != '0);
  assign last_issue = (issued_q + (AW+1)'(1)) == len_q;
  assign hs         = m_valid && m_ready;
  assign final_hs   = (state == DRAIN) && hs && (rem_q == (AW+1)'(1));

  // Credit check: buffered plus in-flight words must leave room for the new issue.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_RD_LATENCY; i++) inflight = inflight + IW'(vld_pipe[i]);
    used  = {1'b0, occ} + (CW+1)'(inflight);
    issue = (state == ISSUE) && (used < (CW+1)'(SKID_DEPTH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (issue && last_issue) state_nxt = DRAIN;
      DRAIN:   if (final_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      issued_q <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      vld_pipe <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[RAM_RD_LATENCY-2:0], issue};
      done     <= ((state == IDLE) && start && (length == '0)) || final_hs;
      if (accept) begin
        len_q    <= length;
        rem_q    <= length;
        issued_q <= '0;
        addr_q   <= base_addr;
      end else begin
        if (issue) begin
          issued_q <= issued_q + 1'b1;
          addr_q   <= addr_q + 1'b1;
        end
        if (hs) rem_q <= rem_q - 1'b1;
      end
    end
  end

`ifdef RAM_RD_LAST_EN
  logic [RAM_RD_LATENCY-1:0] last_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_pipe <= '0;
    else        last_pipe <= {last_pipe[RAM_RD_LATENCY-2:0], issue && last_issue};
  end

  assign fifo_wdata = {last_pipe[RAM_RD_LATENCY-1], ram_read_data};
  assign m_last     = m_valid && fifo_rdata[DATA_WIDTH];
`else
  assign fifo_wdata = ram_read_data;
`endif

  rd_skid_fifo #(
    .DATA_WIDTH (FW),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vld_pipe[RAM_RD_LATENCY-1]),
    .wr_data (fifo_wdata),
    .rd_en   (hs),
    .rd_data (fifo_rdata),
    .count   (occ)
  );

  assign busy             = (state != IDLE);
  assign ram_read_address = addr_q;
  assign m_valid          = (occ != '0);
  assign m_data           = fifo_rdata[DATA_WIDTH-1:0];

endmodule
